// File: rtl/weight_buffer_loader.sv
// Write-side feeder for the CNN weight buffer: turns a valid/ready weight stream into
// single-cycle buffer writes per load job. Define WEIGHT_LOADER_CHECKSUM_EN to add the running checksum output.
module weight_buffer_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ADDR_W:0]            length,
    input  logic                       abort,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       wrb,
    output logic [ADDR_W-1:0]          wrb_addr,
    output logic [DATA_W-1:0]          wrb_data,
    output logic                       busy,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic                       done,
    output logic signed [DATA_W+3:0]   checksum
`else
    output logic                       done
`endif
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                wrb_q, wrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [ADDR_W:0]     len_clamped;
    logic                job_start;
    logic                accept;
    logic                last_word;

    assign len_clamped = (length > DEPTH) ? DEPTH : length;
    assign job_start   = (state_q == IDLE) && start && !abort;
    // A handshake coinciding with abort is dropped, so it never counts or writes.
    assign accept      = (state_q == LOAD) && in_valid && !abort;
    assign last_word   = (count_q == (len_q - 1'b1));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        count_d = count_q;
        wrb_d   = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (job_start) begin
                    base_d  = base_addr;
                    len_d   = len_clamped;
                    count_d = '0;
                    state_d = (len_clamped == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    wrb_d   = 1'b1;
                    addr_d  = base_q + count_q[ADDR_W-1:0];
                    data_d  = in_data;
                    count_d = count_q + 1'b1;
                    if (last_word) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            wrb_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            count_q <= count_d;
            wrb_q   <= wrb_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q == LOAD);
    assign done     = (state_q == DONE);
    assign wrb      = wrb_q;
    assign wrb_addr = addr_q;
    assign wrb_data = data_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic signed [DATA_W+3:0] checksum_q, checksum_d;

    // The sum keeps its partial value on abort and is only cleared by a new job.
    always_comb begin
        checksum_d = checksum_q;
        if (job_start) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q + {{4{in_data[DATA_W-1]}}, in_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Randomized scoreboard bench for weight_buffer_loader; a job-level model predicts every buffer write.
module tb_weight_buffer_loader;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               in_valid = 1'b0;
    logic [ADDR_W-1:0]  base_addr = '0;
    logic [ADDR_W:0]    length = '0;
    logic [DATA_W-1:0]  in_data = '0;
    logic               in_ready;
    logic               wrb;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  wrb_addr;
    logic [DATA_W-1:0]  wrb_data;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic signed [DATA_W+3:0] checksum;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_seen = 0;

    typedef struct {
        int addr;
        int data;
        int last;
        int chk;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int   dir_data[$];
    int   dir_valid[$];

    weight_buffer_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wrb       (wrb),
        .wrb_addr  (wrb_addr),
        .wrb_data  (wrb_data),
        .busy      (busy),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        .done      (done),
        .checksum  (checksum)
`else
        .done      (done)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int st, input int b, input int l, input int ab, input int v, input int d);
        start     = st[0];
        base_addr = b[ADDR_W-1:0];
        length    = l[ADDR_W:0];
        abort     = ab[0];
        in_valid  = v[0];
        in_data   = d[DATA_W-1:0];
    endtask

    function automatic int signed8(input int x);
        logic signed [7:0] b;
        b = x[7:0];
        return b;
    endfunction

    // Monitor: every write the DUT presents is matched against the oldest prediction.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            if (done) done_seen++;
            if (wrb) begin
                checkOutput("wrb_expected", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    checkOutput("wrb_latency", cyc, e.due);
                    checkOutput("wrb_addr", int'(wrb_addr), e.addr);
                    checkOutput("wrb_data", int'(wrb_data), e.data);
                    checkOutput("done_with_last_wrb", int'(done), e.last);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    checkOutput("checksum", int'(checksum), e.chk);
`endif
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                checkOutput("missing_wrb", int'(wrb), 1);
                sb_q.delete(0);
            end
        end
    end

    // Reference model of one job: base/len in, expected writes and done pulse out.
    task automatic runJob(input int base, input int len, input int abort_at);
        int eff, sent, sum, done0, v, d, aborted, step;
        exp_t e;
        eff     = (len > 16) ? 16 : len;
        sent    = 0;
        sum     = 0;
        aborted = 0;
        step    = 0;
        done0   = done_seen;
        applyStimulus(1, base, len, 0, 0, 0);
        @(negedge clk);
        if (eff == 0) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("len0_done", int'(done), 1);
            checkOutput("len0_busy", int'(busy), 0);
            @(negedge clk);
        end else begin
            while (sent < eff && step < 400) begin
                checkOutput("load_in_ready", int'(in_ready), 1);
                checkOutput("load_busy", int'(busy), 1);
                if (sent == abort_at) begin
                    applyStimulus(0, 0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 255));
                    @(negedge clk);
                    checkOutput("abort_busy", int'(busy), 0);
                    checkOutput("abort_in_ready", int'(in_ready), 0);
                    checkOutput("abort_done", int'(done), 0);
                    aborted = 1;
                    break;
                end
                if (dir_valid.size() > 0) v = dir_valid.pop_front();
                else v = ($urandom_range(0, 3) != 0) ? 1 : 0;
                if (v != 0 && dir_data.size() > 0) d = dir_data.pop_front();
                else d = $urandom_range(0, 255);
                applyStimulus(($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 15),
                              $urandom_range(0, 20), 0, v, d);
                if (v != 0) begin
                    sum += signed8(d);
                    e.addr = (base + sent) % 16;
                    e.data = d & 255;
                    e.last = (sent == eff - 1) ? 1 : 0;
                    e.chk  = sum;
                    e.due  = cyc + 1;
                    sb_q.push_back(e);
                    sent++;
                end
                step++;
                @(negedge clk);
            end
            if (aborted == 0) begin
                checkOutput("done_state_busy", int'(busy), 0);
                checkOutput("done_state_in_ready", int'(in_ready), 0);
                applyStimulus(1, $urandom_range(0, 15), $urandom_range(1, 20), 0, 0, 0);
                @(negedge clk);
                checkOutput("start_in_done_ignored", int'(busy), 0);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("done_pulses", done_seen - done0, (aborted != 0) ? 0 : 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int len, eff, ab, d, sum;
        exp_t e;
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_wrb", int'(wrb), 0);
        checkOutput("reset_wrb_addr", int'(wrb_addr), 0);
        checkOutput("reset_wrb_data", int'(wrb_data), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_in_ready", int'(in_ready), 0);
        checkOutput("reset_done", int'(done), 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        checkOutput("reset_checksum", int'(checksum), 0);
`endif
        reset = 1'b1;
        @(negedge clk);

        dir_data  = '{1, 2, 3, 4, 5};
        dir_valid = '{1, 1, 1, 1, 1};
        runJob(0, 5, -1);

        dir_data  = '{-1, -128, 127, 19};
        dir_valid = '{1, 1, 1, 1};
        runJob(14, 4, -1);

        dir_valid = '{1, 0, 0, 1, 0, 1};
        runJob(9, 3, -1);

        runJob(6, 0, -1);
        runJob(3, 20, -1);

        dir_valid = '{1, 1};
        runJob(2, 6, 2);
        runJob(8, 6, -1);

        applyStimulus(1, 3, 5, 1, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("abort_beats_start", int'(busy), 0);
        @(negedge clk);

        for (int j = 0; j < 24; j++) begin
            len = $urandom_range(0, 20);
            eff = (len > 16) ? 16 : len;
            ab  = -1;
            if (eff > 0 && $urandom_range(0, 4) == 0) ab = $urandom_range(0, eff - 1);
            runJob($urandom_range(0, 15), len, ab);
        end

        // Reset lands on a cycle that is presenting a write and offering another handshake.
        applyStimulus(1, 5, 10, 0, 0, 0);
        @(negedge clk);
        sum = 0;
        for (int k = 0; k < 3; k++) begin
            d = $urandom_range(0, 255);
            applyStimulus(0, 0, 0, 0, 1, d);
            sum += signed8(d);
            e.addr = (5 + k) % 16;
            e.data = d;
            e.last = 0;
            e.chk  = sum;
            e.due  = cyc + 1;
            sb_q.push_back(e);
            @(negedge clk);
        end
        applyStimulus(0, 0, 0, 0, 1, $urandom_range(0, 255));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midjob_reset_wrb", int'(wrb), 0);
        checkOutput("midjob_reset_busy", int'(busy), 0);
        checkOutput("midjob_reset_in_ready", int'(in_ready), 0);
        checkOutput("midjob_reset_done", int'(done), 0);
        checkOutput("midjob_reset_wrb_addr", int'(wrb_addr), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_wrb", int'(wrb), 0);
        checkOutput("post_reset_busy", int'(busy), 0);
        runJob(3, 7, -1);

        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
